// File: rtl/pc_seq.sv
// Fetch-stage program counter with condition-gated relative branches,
// absolute jumps and call/return through a small return-address stack.
module pc_seq #(
  parameter int D         = 12,
  parameter int OFF_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             reljump_en,
  input  logic             absjump_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [2:0]       cond_sel,
  input  logic             flag_eq,
  input  logic             flag_lt,
  input  logic             flag_gt,
  input  logic [OFF_W-1:0] offset,
  input  logic [D-1:0]     target,
  output logic [D-1:0]     prog_ctr,
  output logic             taken,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int IW = $clog2(RAS_DEPTH);

  logic [D-1:0]  pc_reg, pc_next;
  logic          taken_reg, taken_next;
  logic          err_reg, err_next;
  logic [CW-1:0] count_reg, count_next;
  logic          push;
  logic          cond_true;
  logic [D-1:0]  pc_plus1;
  logic [D-1:0]  offset_sext;
  logic [D-1:0]  ras_top;
  logic [IW-1:0] top_idx;
  logic [RAS_DEPTH-1:0] wr_en;

  logic [D-1:0] ras_mem [RAS_DEPTH];

  // Offsets at least as wide as the PC are simply truncated to D bits.
  generate
    if (OFF_W >= D) begin : g_off_trunc
      assign offset_sext = offset[D-1:0];
    end else begin : g_off_sext
      assign offset_sext = {{(D-OFF_W){offset[OFF_W-1]}}, offset};
    end
  endgenerate

  assign pc_plus1  = pc_reg + D'(1);
  assign ras_empty = (count_reg == '0);
  assign ras_full  = (count_reg == CW'(RAS_DEPTH));
  assign top_idx   = IW'(count_reg - CW'(1));
  assign ras_top   = ras_mem[top_idx];

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      3'b000:  cond_true = flag_eq;
      3'b001:  cond_true = !flag_eq;
      3'b010:  cond_true = flag_lt;
      3'b011:  cond_true = flag_gt;
      3'b100:  cond_true = flag_eq | flag_lt;
      3'b101:  cond_true = flag_eq | flag_gt;
      3'b110:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    pc_next    = pc_plus1;
    taken_next = 1'b0;
    err_next   = err_reg;
    count_next = count_reg;
    push       = 1'b0;
    if (stall) begin
      pc_next    = pc_reg;
      taken_next = taken_reg;
    end else if (ret_en) begin
      if (!ras_empty) begin
        pc_next    = ras_top;
        count_next = count_reg - CW'(1);
        taken_next = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end else if (call_en) begin
      // The jump happens even when the stack is full; only the push is lost.
      pc_next    = target;
      taken_next = 1'b1;
      if (!ras_full) begin
        push       = 1'b1;
        count_next = count_reg + CW'(1);
      end else begin
        err_next = 1'b1;
      end
    end else if (absjump_en) begin
      pc_next    = target;
      taken_next = 1'b1;
    end else if (reljump_en && cond_true) begin
      pc_next    = pc_reg + offset_sext;
      taken_next = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_wr
      assign wr_en[gi] = push && (count_reg == CW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= '0;
      taken_reg <= 1'b0;
      err_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      pc_reg    <= pc_next;
      taken_reg <= taken_next;
      err_reg   <= err_next;
      count_reg <= count_next;
    end
  end

  // Entry contents need no reset: count alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (!reset && wr_en[i]) ras_mem[i] <= pc_plus1;
    end
  end

  assign prog_ctr = pc_reg;
  assign taken    = taken_reg;
  assign ras_err  = err_reg;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: stimulus queues hand-computed expectations,
// a separate monitor pops and compares them one cycle at a time.
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        reset, stall, reljump_en, absjump_en, call_en, ret_en;
  logic [2:0]  cond_sel;
  logic        flag_eq, flag_lt, flag_gt;
  logic [7:0]  offset;
  logic [11:0] target;
  logic [11:0] prog_ctr;
  logic        taken, ras_empty, ras_full, ras_err;

  typedef struct {
    string       name;
    logic [11:0] pc;
    logic        tk;
    logic        emp;
    logic        ful;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  pc_seq #(.D(12), .OFF_W(8), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .reljump_en(reljump_en), .absjump_en(absjump_en),
    .call_en(call_en), .ret_en(ret_en), .cond_sel(cond_sel),
    .flag_eq(flag_eq), .flag_lt(flag_lt), .flag_gt(flag_gt),
    .offset(offset), .target(target), .prog_ctr(prog_ctr),
    .taken(taken), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_err(ras_err)
  );

  task automatic clear_in();
    reset = 0; stall = 0; reljump_en = 0; absjump_en = 0;
    call_en = 0; ret_en = 0; cond_sel = 3'b111;
    flag_eq = 0; flag_lt = 0; flag_gt = 0; offset = '0; target = '0;
  endtask

  // Apply the currently driven inputs for one edge and queue the expectation.
  task automatic go(input string name, input logic [11:0] pc, input logic tk,
                    input logic emp, input logic ful, input logic err);
    exp_t e;
    @(posedge clk);
    e.name = name; e.pc = pc; e.tk = tk; e.emp = emp; e.ful = ful; e.err = err;
    sb.push_back(e);
    @(negedge clk);
    clear_in();
  endtask

  task automatic jmp(input string name, input logic [11:0] t, input logic emp,
                     input logic ful, input logic err);
    absjump_en = 1; target = t;
    go(name, t, 1, emp, ful, err);
  endtask

  task automatic rel(input string name, input logic [2:0] cs, input logic eq,
                     input logic lt, input logic gt, input logic [7:0] off,
                     input logic [11:0] pc, input logic tk);
    reljump_en = 1; cond_sel = cs; flag_eq = eq; flag_lt = lt; flag_gt = gt;
    offset = off;
    go(name, pc, tk, 1, 0, 0);
  endtask

  // Monitor: outputs are all registered, so sample on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({prog_ctr, taken, ras_empty, ras_full, ras_err} !==
            {e.pc, e.tk, e.emp, e.ful, e.err}) begin
          errors++;
          $display("FAIL %s: got pc=%03h tk=%b emp=%b ful=%b err=%b, want pc=%03h tk=%b emp=%b ful=%b err=%b",
                   e.name, prog_ctr, taken, ras_empty, ras_full, ras_err,
                   e.pc, e.tk, e.emp, e.ful, e.err);
        end else begin
          $display("ok   %s: pc=%03h tk=%b emp=%b ful=%b err=%b",
                   e.name, prog_ctr, taken, ras_empty, ras_full, ras_err);
        end
      end
    end
  end

  initial begin
    clear_in();
    reset = 1;
    go("reset", 12'h000, 0, 1, 0, 0);
    go("idle1", 12'h001, 0, 1, 0, 0);
    go("idle2", 12'h002, 0, 1, 0, 0);
    go("idle3", 12'h003, 0, 1, 0, 0);

    // Relative branches over all condition codes
    jmp("abs_010", 12'h010, 1, 0, 0);
    rel("rel_eq_t",  3'b000, 1, 0, 0, 8'hFC, 12'h00C, 1);
    jmp("abs_010b", 12'h010, 1, 0, 0);
    rel("rel_eq_f",  3'b000, 0, 0, 0, 8'hFC, 12'h011, 0);
    rel("rel_lt_t",  3'b010, 0, 1, 0, 8'h05, 12'h016, 1);
    rel("rel_le_f",  3'b100, 0, 0, 1, 8'h05, 12'h017, 0);
    rel("rel_ge_t",  3'b101, 0, 0, 1, 8'h02, 12'h019, 1);
    rel("rel_never", 3'b111, 1, 1, 1, 8'h02, 12'h01A, 0);
    rel("rel_ne_t",  3'b001, 0, 0, 0, 8'h10, 12'h02A, 1);
    rel("rel_gt_f",  3'b011, 0, 1, 0, 8'h10, 12'h02B, 0);

    // Call and return
    jmp("abs_020", 12'h020, 1, 0, 0);
    call_en = 1; target = 12'h100; go("call_100", 12'h100, 1, 0, 0, 0);
    go("idle_101", 12'h101, 0, 0, 0, 0);
    go("idle_102", 12'h102, 0, 0, 0, 0);
    ret_en = 1; go("ret_021", 12'h021, 1, 1, 0, 0);

    // Fill the stack, overflow, then drain past empty
    call_en = 1; target = 12'h300; go("call1", 12'h300, 1, 0, 0, 0);
    call_en = 1; target = 12'h310; go("call2", 12'h310, 1, 0, 0, 0);
    call_en = 1; target = 12'h320; go("call3", 12'h320, 1, 0, 0, 0);
    call_en = 1; target = 12'h330; go("call4_full", 12'h330, 1, 0, 1, 0);
    call_en = 1; target = 12'h200; go("call5_ovf", 12'h200, 1, 0, 1, 1);
    ret_en = 1; go("ret1", 12'h321, 1, 0, 0, 1);
    ret_en = 1; go("ret2", 12'h311, 1, 0, 0, 1);
    ret_en = 1; go("ret3", 12'h301, 1, 0, 0, 1);
    ret_en = 1; go("ret4", 12'h022, 1, 1, 0, 1);
    ret_en = 1; go("ret5_unf", 12'h023, 0, 1, 0, 1);

    // Stall holds everything; return beats absolute jump
    call_en = 1; target = 12'h050; go("call_050", 12'h050, 1, 0, 0, 1);
    stall = 1; call_en = 1; target = 12'h400; go("stall1", 12'h050, 1, 0, 0, 1);
    stall = 1; call_en = 1; target = 12'h400; go("stall2", 12'h050, 1, 0, 0, 1);
    ret_en = 1; absjump_en = 1; target = 12'h400; go("ret_vs_abs", 12'h024, 1, 1, 0, 1);

    // Wrap-around and reset during a call
    jmp("abs_fff", 12'hFFF, 1, 0, 1);
    go("wrap", 12'h000, 0, 1, 0, 1);
    jmp("abs_005", 12'h005, 1, 0, 1);
    reljump_en = 1; cond_sel = 3'b110; offset = 8'h80;
    go("rel_neg", 12'hF85, 1, 1, 0, 1);
    call_en = 1; target = 12'h123; go("call_123", 12'h123, 1, 0, 0, 1);
    reset = 1; call_en = 1; target = 12'h456; go("reset_call", 12'h000, 0, 1, 0, 0);
    go("post_reset", 12'h001, 0, 1, 0, 0);

    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (sb.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    #1;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, want completion");
    $fatal(1);
  end

endmodule
